// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM encoding, PC step and
// the {pc, instruction} record held in the skid buffer.
`ifndef FETCH_SEQUENCER_PKG_SV
`define FETCH_SEQUENCER_PKG_SV
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INCREMENT = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage
`endif

// File: rtl/fetch_sequencer_if.sv
// Fetch-path bundle: redirect input, instruction-memory port and the decode
// handshake. master = sequencer side, slave = memory/decode/branch side.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  redirect_valid;
  logic [31:0]           redirect_target;
  logic                  decode_ready;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_data;
  logic                  fetch_valid;
  logic [31:0]           fetch_instruction;
  logic [31:0]           fetch_pc;
  logic                  fetch_fault;

  modport master (
    input  redirect_valid, redirect_target, decode_ready, imem_data,
    output imem_address, fetch_valid, fetch_instruction, fetch_pc, fetch_fault
  );

  modport slave (
    output redirect_valid, redirect_target, decode_ready, imem_data,
    input  imem_address, fetch_valid, fetch_instruction, fetch_pc, fetch_fault
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetched {pc, instruction}; entry 0 is always the head.
// Flush wins over push/pop; push and pop on the same edge are both honoured.
module fetch_skid_buffer
  import fetch_sequencer_pkg::*;
(
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry [2];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count    <= 2'd0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          entry[count[0]] <= push_entry;
          count           <= count + 2'd1;
        end
        2'b01: begin
          entry[0] <= entry[1];
          count    <= count - 2'd1;
        end
        2'b11: begin
          // count is 1 or 2 here; new word lands behind whatever survives the pop
          if (count == 2'd1) begin
            entry[0] <= push_entry;
          end else begin
            entry[0] <= entry[1];
            entry[1] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues word addresses to instruction memory and
// feeds returned words through a 2-entry skid buffer to decode.
//
//   state       | meaning
//   FETCH_IDLE  | first edge after reset release, nothing issued
//   FETCH_RUN   | issuing, buffering, honouring redirects
//   FETCH_FAULT | misaligned redirect seen; frozen until reset
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic              system_clock,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fetch_sequencer: BUF_DEPTH must be 2");
  end
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_vector
    $error("fetch_sequencer: RESET_VECTOR must be word aligned");
  end

  fetch_state_t          state;
  logic [31:0]           issue_pc;
  logic [31:0]           inflight_pc;
  logic                  inflight;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] imem_address;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         fetch_valid;
  logic         pop;
  logic         push;
  logic         flush;
  logic         misaligned;
  logic         issue;
  logic [2:0]   occupancy;

  always_comb begin
    fetch_valid = (count != 2'd0);
    flush       = (state == FETCH_RUN) && bus.redirect_valid;
    misaligned  = (bus.redirect_target[1:0] != 2'b00);
    pop         = fetch_valid && bus.decode_ready;
    push        = inflight && !flush;
    push_entry  = '{pc: inflight_pc, instruction: bus.imem_data};
    // Words that will occupy the buffer after this edge; issuing keeps it <= 2.
    occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue       = (state == FETCH_RUN) && (occupancy < 3'd2);
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state        <= FETCH_IDLE;
      issue_pc     <= RESET_VECTOR;
      imem_address <= RESET_VECTOR[ADDR_WIDTH+1:2];
      inflight     <= 1'b0;
      inflight_pc  <= 32'd0;
      fault        <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          state    <= FETCH_RUN;
          inflight <= 1'b0;
        end
        FETCH_RUN: begin
          if (bus.redirect_valid) begin
            if (misaligned) begin
              state    <= FETCH_FAULT;
              fault    <= 1'b1;
              inflight <= 1'b0;
            end else begin
              imem_address <= bus.redirect_target[ADDR_WIDTH+1:2];
              issue_pc     <= bus.redirect_target + PC_INCREMENT;
              inflight     <= 1'b1;
              inflight_pc  <= bus.redirect_target;
            end
          end else if (issue) begin
            imem_address <= issue_pc[ADDR_WIDTH+1:2];
            issue_pc     <= issue_pc + PC_INCREMENT;
            inflight     <= 1'b1;
            inflight_pc  <= issue_pc;
          end else begin
            inflight <= 1'b0;
          end
        end
        default: begin
          inflight <= 1'b0;
        end
      endcase
    end
  end

  fetch_skid_buffer u_buffer (
    .clk_sys    (system_clock),
    .rst_b      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .count      (count),
    .head       (head)
  );

  assign bus.imem_address      = imem_address;
  assign bus.fetch_valid       = fetch_valid;
  assign bus.fetch_instruction = head.instruction;
  assign bus.fetch_pc          = head.pc;
  assign bus.fetch_fault       = fault;

endmodule
